// File: rtl/cla_nibble_sequencer.sv
// ============================================================================
// cla_nibble_sequencer : nibble-serial add/subtract driving a shared 4-bit CLA
// Revision: 1.0
// ============================================================================
`default_nettype none

module cla_nibble_sequencer #(
  parameter int WIDTH   = 32,
  parameter int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_sum,
  input  logic             slice_cout
);

  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              carry_out_q, carry_out_d;
  logic              overflow_q, overflow_d;
  logic [IDXW+1:0]   nib_base;

  assign nib_base = {idx_q, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    slice_a     = 4'h0;
    slice_b     = 4'h0;
    slice_cin   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Subtract is a + ~b + 1: invert B once here, seed carry with op.
          op_a_d      = a;
          op_b_d      = op ? ~b : b;
          carry_d     = op;
          idx_d       = '0;
          result_d    = '0;
          carry_out_d = 1'b0;
          overflow_d  = 1'b0;
          state_d     = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        slice_a   = op_a_q[nib_base +: 4];
        slice_b   = op_b_q[nib_base +: 4];
        slice_cin = carry_q;
        result_d[nib_base +: 4] = slice_sum;
        carry_d   = slice_cout;
        idx_d     = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          carry_out_d = slice_cout;
          overflow_d  = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                        (slice_sum[3] != op_a_q[WIDTH-1]);
          idx_d       = '0;
          state_d     = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_cla_nibble_sequencer.sv
// ============================================================================
// tb_cla_nibble_sequencer : directed-vector bench with a behavioural CLA slice
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cla_nibble_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  logic        carry_out, overflow;
  logic [3:0]  slice_a, slice_b, slice_sum;
  logic        slice_cin, slice_cout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};

  cla_nibble_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .overflow(overflow), .slice_a(slice_a), .slice_b(slice_b),
    .slice_cin(slice_cin), .slice_sum(slice_sum), .slice_cout(slice_cout)
  );

  // Called at the negedge right after the accept edge; returns at the done negedge.
  task automatic wait_done(output int lat, output int bcnt, output logic [7:0] cins);
    lat = 0; bcnt = 0; cins = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      if (busy) begin
        bcnt++;
        if (i <= 8) cins[i-1] = slice_cin;
      end
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_op(input logic op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                       output int lat, output int bcnt, output logic [7:0] cins);
    @(negedge clk);
    start = 1'b1; op = op_v; a = a_v; b = b_v;
    @(negedge clk);
    start = 1'b0; op = ~op_v; a = $urandom; b = $urandom;
    wait_done(lat, bcnt, cins);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, carry_out, overflow, slice_cin} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00000", {busy, done, carry_out, overflow, slice_cin});
    end
    n_cmp++;
    if (result !== 32'h0 || slice_a !== 4'h0 || slice_b !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_data: result=%h slice_a=%h slice_b=%h want all 0", result, slice_a, slice_b);
    end
    reset = 1'b0;
  endtask

  task automatic test_add_basic;
    int lat, bcnt; logic [7:0] cins;
    do_op(1'b0, 32'h1, 32'h1, lat, bcnt, cins);
    n_cmp++;
    if (result !== 32'h2 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL add_1p1: got %h co=%b ov=%b want 00000002 co=0 ov=0", result, carry_out, overflow);
    end
    n_cmp++;
    if (lat !== 9) begin
      n_bad++;
      $display("FAIL add_latency: got %0d want 9", lat);
    end
    n_cmp++;
    if (bcnt !== 8) begin
      n_bad++;
      $display("FAIL busy_cycles: got %0d want 8", bcnt);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || result !== 32'h2) begin
      n_bad++;
      $display("FAIL done_pulse_hold: done=%b result=%h want 0 00000002", done, result);
    end
  endtask

  task automatic test_add_ripple;
    int lat, bcnt; logic [7:0] cins;
    do_op(1'b0, 32'hFFFF_FFFF, 32'h1, lat, bcnt, cins);
    n_cmp++;
    if (result !== 32'h0 || carry_out !== 1'b1 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL add_ripple: got %h co=%b ov=%b want 00000000 co=1 ov=0", result, carry_out, overflow);
    end
    n_cmp++;
    if (cins !== 8'hFE) begin
      n_bad++;
      $display("FAIL ripple_cin_trace: got %b want 11111110", cins);
    end
  endtask

  task automatic test_sub;
    int lat, bcnt; logic [7:0] cins;
    do_op(1'b1, 32'h5, 32'h7, lat, bcnt, cins);
    n_cmp++;
    if (result !== 32'hFFFF_FFFE || carry_out !== 1'b0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL sub_5m7: got %h co=%b ov=%b want fffffffe co=0 ov=0", result, carry_out, overflow);
    end
    do_op(1'b1, 32'h7, 32'h5, lat, bcnt, cins);
    n_cmp++;
    if (result !== 32'h2 || carry_out !== 1'b1 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL sub_7m5: got %h co=%b ov=%b want 00000002 co=1 ov=0", result, carry_out, overflow);
    end
  endtask

  task automatic test_overflow;
    int lat, bcnt; logic [7:0] cins;
    do_op(1'b0, 32'h7FFF_FFFF, 32'h1, lat, bcnt, cins);
    n_cmp++;
    if (result !== 32'h8000_0000 || carry_out !== 1'b0 || overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_add: got %h co=%b ov=%b want 80000000 co=0 ov=1", result, carry_out, overflow);
    end
    do_op(1'b1, 32'h8000_0000, 32'h1, lat, bcnt, cins);
    n_cmp++;
    if (result !== 32'h7FFF_FFFF || carry_out !== 1'b1 || overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_sub: got %h co=%b ov=%b want 7fffffff co=1 ov=1", result, carry_out, overflow);
    end
  endtask

  task automatic test_start_ignored;
    int lat, bcnt; logic [7:0] cins;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'h10; b = 32'h20;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'hAAAA_AAAA; b = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt, cins);
    n_cmp++;
    if (result !== 32'h30 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL start_ignored: got %h co=%b ov=%b want 00000030 co=0 ov=0", result, carry_out, overflow);
    end
    n_cmp++;
    if (lat !== 6) begin
      n_bad++;
      $display("FAIL ignored_latency: got %0d remaining cycles want 6", lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt; logic [7:0] cins;
    do_op(1'b0, 32'h3, 32'h4, lat, bcnt, cins);
    n_cmp++;
    if (result !== 32'h7) begin
      n_bad++;
      $display("FAIL b2b_first: got %h want 00000007", result);
    end
    start = 1'b1; op = 1'b0; a = 32'h0000_FFFF; b = 32'h1;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    wait_done(lat, bcnt, cins);
    n_cmp++;
    if (result !== 32'h0001_0000 || lat !== 9) begin
      n_bad++;
      $display("FAIL b2b_second: got %h lat=%0d want 00010000 lat=9", result, lat);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat, bcnt; logic [7:0] cins;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({busy, done, carry_out, overflow, slice_cin} !== 5'b0 || result !== 32'h0 ||
        slice_a !== 4'h0 || slice_b !== 4'h0) begin
      n_bad++;
      $display("FAIL mid_run_reset: busy=%b done=%b co=%b ov=%b cin=%b result=%h sa=%h sb=%h want all 0",
               busy, done, carry_out, overflow, slice_cin, result, slice_a, slice_b);
    end
    bcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) bcnt++;
    end
    n_cmp++;
    if (bcnt !== 0) begin
      n_bad++;
      $display("FAIL aborted_activity: got %0d busy/done cycles want 0", bcnt);
    end
    do_op(1'b0, 32'h1234_5678, 32'h1111_1111, lat, bcnt, cins);
    n_cmp++;
    if (result !== 32'h2345_6789 || carry_out !== 1'b0 || overflow !== 1'b0 || lat !== 9) begin
      n_bad++;
      $display("FAIL after_reset_add: got %h co=%b ov=%b lat=%0d want 23456789 co=0 ov=0 lat=9",
               result, carry_out, overflow, lat);
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_add_ripple();
    test_sub();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
